// File: rtl/kyber_pkg.sv
// Constants, FSM state type and the legal-d check used by the ML-KEM
// polynomial decode datapath.
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEF_W  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic d_is_legal(input logic [3:0] d);
    return (d == 4'd1) || (d == 4'd4) || (d == 4'd5) ||
           (d == 4'd10) || (d == 4'd11) || (d == 4'd12);
  endfunction
endpackage

// File: rtl/poly_byte_decode_if.sv
// Byte-stream input and coefficient-beat output handshakes of poly_byte_decode.
interface poly_byte_decode_if #(
  parameter int IN_W = 64,
  parameter int NC   = 4
);
  logic [IN_W-1:0]  i_ibytes;
  logic             i_ibytes_valid;
  logic             o_ibytes_ready;
  logic [NC*12-1:0] o_coeffs;
  logic             o_coeffs_valid;
  logic             i_coeffs_ready;

  modport slave (
    input  i_ibytes, i_ibytes_valid, i_coeffs_ready,
    output o_ibytes_ready, o_coeffs, o_coeffs_valid
  );

  modport master (
    output i_ibytes, i_ibytes_valid, i_coeffs_ready,
    input  o_ibytes_ready, o_coeffs, o_coeffs_valid
  );
endinterface

// File: rtl/kyber_decompress.sv
// One coefficient lane: optional Decompress_d for d<12, mod-q reduction and
// over-q flag for d=12.
module kyber_decompress
  import kyber_pkg::*;
(
  input  logic [COEF_W-1:0] i_x,
  input  logic [3:0]        i_d,
  input  logic              i_decomp,
  output logic [COEF_W-1:0] o_y,
  output logic              o_over_q
);
  logic [23:0]       w_prod;
  logic [23:0]       w_round;
  logic [COEF_W-1:0] w_scaled;

  always_comb begin
    w_prod   = 24'(i_x) * 24'(KYBER_Q);
    w_round  = 24'd1 << (i_d - 4'd1);
    w_scaled = COEF_W'((w_prod + w_round) >> i_d);
    o_over_q = 1'b0;
    o_y      = i_x;
    if (i_d == 4'd12) begin
      o_over_q = (i_x >= COEF_W'(KYBER_Q));
      if (o_over_q) o_y = i_x - COEF_W'(KYBER_Q);
    end else if (i_decomp) begin
      o_y = w_scaled;
    end
  end
endmodule

// File: rtl/poly_byte_decode.sv
// Streaming ByteDecode_d / Decompress_d: unpacks a packed byte stream into
// NC 12-bit coefficients per beat, one 256-coefficient polynomial per start.
//
//   state | meaning
//   IDLE  | waiting for i_start; illegal d sets o_err
//   RUN   | accepting words into the bit buffer and emitting beats
//   DONE  | one-cycle o_done pulse after the last beat handshake
module poly_byte_decode
  import kyber_pkg::*;
#(
  parameter int IN_W = 64,
  parameter int NC   = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [3:0]        i_d,
  input  logic              i_decomp,
  poly_byte_decode_if.slave io,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int BUF_W  = IN_W + NC * COEF_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int CNT_W  = 10;

  state_t                 r_state;
  logic [3:0]             r_d;
  logic                   r_decomp;
  logic [BUF_W-1:0]       r_buf;
  logic [FILL_W-1:0]      r_fill;
  logic [CNT_W-1:0]       r_words_left;
  logic [CNT_W-1:0]       r_beats_left;
  logic [NC*COEF_W-1:0]   r_coeffs;
  logic                   r_valid;
  logic                   r_err;

  logic [FILL_W-1:0]      w_beat_bits;
  logic                   w_in_ok;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_extract;
  logic [FILL_W-1:0]      w_shift;
  logic [FILL_W-1:0]      w_fill_shr;
  logic [BUF_W-1:0]       w_buf_shr;
  logic [BUF_W-1:0]       w_buf_next;
  logic [FILL_W-1:0]      w_fill_next;
  logic [BUF_W-1:0]       w_mask;
  logic [COEF_W-1:0]      w_lane_x [NC];
  logic [COEF_W-1:0]      w_lane_y [NC];
  logic [NC-1:0]          w_lane_over;
  logic [NC*COEF_W-1:0]   w_beat;
  logic                   w_any_over;

  assign w_beat_bits = FILL_W'(NC) * FILL_W'(r_d);
  // Ready depends only on registered state so upstream sees no comb path.
  assign w_in_ok     = (r_state == RUN) && (r_words_left != '0) &&
                       (r_fill <= FILL_W'(BUF_W - IN_W));
  assign w_in_fire   = w_in_ok && io.i_ibytes_valid;
  assign w_out_fire  = r_valid && io.i_coeffs_ready;
  assign w_extract   = (r_state == RUN) && (r_fill >= w_beat_bits) &&
                       (!r_valid || io.i_coeffs_ready);

  assign w_shift     = w_extract ? w_beat_bits : '0;
  assign w_buf_shr   = r_buf >> w_shift;
  assign w_fill_shr  = r_fill - w_shift;
  assign w_buf_next  = w_in_fire ? (w_buf_shr | (BUF_W'(io.i_ibytes) << w_fill_shr))
                                 : w_buf_shr;
  assign w_fill_next = w_fill_shr + (w_in_fire ? FILL_W'(IN_W) : FILL_W'(0));
  assign w_mask      = (BUF_W'(1) << r_d) - BUF_W'(1);

  for (genvar j = 0; j < NC; j++) begin : g_lane
    assign w_lane_x[j] = COEF_W'((r_buf >> (FILL_W'(j) * FILL_W'(r_d))) & w_mask);

    kyber_decompress u_lane (
      .i_x      (w_lane_x[j]),
      .i_d      (r_d),
      .i_decomp (r_decomp),
      .o_y      (w_lane_y[j]),
      .o_over_q (w_lane_over[j])
    );

    assign w_beat[j*COEF_W +: COEF_W] = w_lane_y[j];
  end

  assign w_any_over = |w_lane_over;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= IDLE;
      r_d          <= '0;
      r_decomp     <= 1'b0;
      r_buf        <= '0;
      r_fill       <= '0;
      r_words_left <= '0;
      r_beats_left <= '0;
      r_coeffs     <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (d_is_legal(i_d)) begin
              r_state      <= RUN;
              r_d          <= i_d;
              r_decomp     <= i_decomp;
              r_buf        <= '0;
              r_fill       <= '0;
              r_words_left <= CNT_W'((KYBER_N * int'(i_d)) / IN_W);
              r_beats_left <= CNT_W'(KYBER_N / NC);
              r_valid      <= 1'b0;
              r_err        <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        RUN: begin
          r_buf  <= w_buf_next;
          r_fill <= w_fill_next;
          if (w_in_fire) r_words_left <= r_words_left - CNT_W'(1);
          if (w_extract) begin
            r_coeffs <= w_beat;
            r_valid  <= 1'b1;
            if (w_any_over) r_err <= 1'b1;
          end else if (w_out_fire) begin
            r_valid <= 1'b0;
          end
          if (w_out_fire) begin
            r_beats_left <= r_beats_left - CNT_W'(1);
            if (r_beats_left == CNT_W'(1)) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io.o_ibytes_ready = w_in_ok;
  assign io.o_coeffs       = r_coeffs;
  assign io.o_coeffs_valid = r_valid;
  assign o_busy            = (r_state != IDLE);
  assign o_done            = (r_state == DONE);
  assign o_err             = r_err;
endmodule
